// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX operand forwarding / hazard controller.
// Stage trackers record just enough of each in-flight instruction to resolve RAW hazards.
package fwd_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] SEL_REG = 2'd0;
   localparam logic [1:0] SEL_WB  = 2'd1;
   localparam logic [1:0] SEL_ALU = 2'd2;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } trk_t;

   localparam trk_t TRK_EMPTY = '0;

endpackage

// File: rtl/fwd_match.sv
// RAW match of one source operand against one in-flight producer.
// Purely combinational, no backpressure.
module fwd_match
   import fwd_pkg::*;
(
   input  logic [REG_AW-1:0] rs,
   input  logic              rs_used,
   input  logic              trk_valid,
   input  logic              trk_regwrite,
   input  logic [REG_AW-1:0] trk_rd,
   output logic              match
);

   // x0 is hard-wired zero, so a write to it never produces a forwardable value.
   assign match = rs_used && trk_valid && trk_regwrite &&
                  (trk_rd != '0) && (trk_rd == rs);

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Forwarding selects and load-use stall/bubble for the 5-stage pipeline.
// sel_a/sel_b registered (1 cycle from ID); stall_id/ex_bubble combinational; hold freezes all state.
module fwd_ctrl_unit
   import fwd_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   output logic [1:0]        sel_a,
   output logic [1:0]        sel_b,
   output logic              stall_id,
   output logic              ex_bubble
);

   trk_t       ex_q, mem_q, wb_q;
   logic       m1_ex, m2_ex, m1_mem, m2_mem;
   logic       load_use, adv, take;
   logic [1:0] sel_a_d, sel_b_d;
   logic       dbg_unused;

   fwd_match u_m1_ex (
      .rs(id_rs1), .rs_used(id_rs1_used),
      .trk_valid(ex_q.valid), .trk_regwrite(ex_q.regwrite), .trk_rd(ex_q.rd),
      .match(m1_ex)
   );

   fwd_match u_m2_ex (
      .rs(id_rs2), .rs_used(id_rs2_used),
      .trk_valid(ex_q.valid), .trk_regwrite(ex_q.regwrite), .trk_rd(ex_q.rd),
      .match(m2_ex)
   );

   fwd_match u_m1_mem (
      .rs(id_rs1), .rs_used(id_rs1_used),
      .trk_valid(mem_q.valid), .trk_regwrite(mem_q.regwrite), .trk_rd(mem_q.rd),
      .match(m1_mem)
   );

   fwd_match u_m2_mem (
      .rs(id_rs2), .rs_used(id_rs2_used),
      .trk_valid(mem_q.valid), .trk_regwrite(mem_q.regwrite), .trk_rd(mem_q.rd),
      .match(m2_mem)
   );

   assign adv       = !hold;
   assign load_use  = id_valid && ex_q.memread && (m1_ex || m2_ex);
   assign stall_id  = load_use && !hold && !flush;
   assign ex_bubble = stall_id || (flush && !hold);
   assign take      = id_valid && !ex_bubble;

   // Youngest producer wins; a load hit in EX never reaches here because it forces a bubble.
   always_comb begin
      sel_a_d = SEL_REG;
      sel_b_d = SEL_REG;
      if (m1_ex)       sel_a_d = SEL_ALU;
      else if (m1_mem) sel_a_d = SEL_WB;
      if (m2_ex)       sel_b_d = SEL_ALU;
      else if (m2_mem) sel_b_d = SEL_WB;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= TRK_EMPTY;
         mem_q <= TRK_EMPTY;
         wb_q  <= TRK_EMPTY;
         sel_a <= SEL_REG;
         sel_b <= SEL_REG;
      end else if (adv) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         if (take) begin
            ex_q  <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
            sel_a <= sel_a_d;
            sel_b <= sel_b_d;
         end else begin
            ex_q  <= TRK_EMPTY;
            sel_a <= SEL_REG;
            sel_b <= SEL_REG;
         end
      end
   end

   // Write-before-read register file: the WB tracker is kept for observability only.
   assign dbg_unused = ^wb_q;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Randomized and directed bench for fwd_ctrl_unit against an in-flight instruction history model.
module tb_fwd_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
   logic [1:0] sel_a, sel_b;
   logic       stall_id, ex_bubble;

   int n_cmp = 0;
   int n_bad = 0;

   fwd_ctrl_unit dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .sel_a(sel_a), .sel_b(sel_b), .stall_id(stall_id), .ex_bubble(ex_bubble)
   );

   always #5 clk = ~clk;

   // History of instructions issued into EX: index 0 is in EX, 1 in MEM, 2 in WB.
   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
   } minst_t;

   minst_t pipe[$];
   int     m_sel_a = 0;
   int     m_sel_b = 0;

   // 0 = register file, 1 = MEM/WB value, 2 = ALU result, 3 = needs a load that is still in EX.
   function automatic int fwd_src(int rs, bit used);
      if (!used || rs == 0) return 0;
      for (int d = 0; d < 2; d++) begin
         if (d < pipe.size() && pipe[d].v && pipe[d].wr && pipe[d].rd == rs)
            return (d == 0) ? (pipe[d].ld ? 3 : 2) : 1;
      end
      return 0;
   endfunction

   function automatic void model_eval(output int s1, output int s2, output bit st, output bit bb);
      bit lu;
      s1 = fwd_src(int'(id_rs1), id_rs1_used);
      s2 = fwd_src(int'(id_rs2), id_rs2_used);
      lu = id_valid && (s1 == 3 || s2 == 3);
      st = lu && !hold && !flush;
      bb = st || (flush && !hold);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin : model_upd
      int     s1, s2;
      bit     st, bb, take;
      minst_t e;
      if (!rst_n) begin
         pipe.delete();
         m_sel_a <= 0;
         m_sel_b <= 0;
      end else if (!hold) begin
         model_eval(s1, s2, st, bb);
         take = id_valid && !bb;
         e.v  = take;
         e.rd = take ? int'(id_rd) : 0;
         e.wr = take && id_regwrite;
         e.ld = take && id_memread;
         pipe.push_front(e);
         if (pipe.size() > 3) void'(pipe.pop_back());
         m_sel_a <= take ? s1 : 0;
         m_sel_b <= take ? s2 : 0;
      end
   end

   always @(negedge clk) begin : compare
      int s1, s2;
      bit st, bb;
      model_eval(s1, s2, st, bb);
      chk("model stall_id", int'(stall_id), int'(st));
      chk("model ex_bubble", int'(ex_bubble), int'(bb));
      chk("model sel_a", int'(sel_a), m_sel_a);
      chk("model sel_b", int'(sel_b), m_sel_b);
   end

   task automatic ins(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                      input int rd, input bit wr, input bit ld);
      id_valid    = v;
      id_rs1      = 5'(rs1);
      id_rs2      = 5'(rs2);
      id_rs1_used = u1;
      id_rs2_used = u2;
      id_rd       = 5'(rd);
      id_regwrite = wr;
      id_memread  = ld;
   endtask

   task automatic nop();
      ins(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drain();
      nop();
      repeat (3) step();
   endtask

   initial begin
      #3;
      chk("reset sel_a", int'(sel_a), 0);
      chk("reset sel_b", int'(sel_b), 0);
      chk("reset stall_id", int'(stall_id), 0);
      chk("reset ex_bubble", int'(ex_bubble), 0);
      step();
      rst_n = 1'b1;
      step();

      // ADD x3,x1,x2 ; SUB x5,x3,x4
      ins(1, 1, 2, 1, 1, 3, 1, 0); step();
      ins(1, 3, 4, 1, 1, 5, 1, 0); settle();
      chk("b2b stall_id", int'(stall_id), 0);
      step();
      nop(); settle();
      chk("b2b sel_a", int'(sel_a), 2);
      chk("b2b sel_b", int'(sel_b), 0);
      drain();

      // ADD x3 ; NOP ; OR x6,x3,x3
      ins(1, 1, 2, 1, 1, 3, 1, 0); step();
      nop(); step();
      ins(1, 3, 3, 1, 1, 6, 1, 0); step();
      nop(); settle();
      chk("dist2 sel_a", int'(sel_a), 1);
      chk("dist2 sel_b", int'(sel_b), 1);
      drain();

      // LW x7 ; AND x8,x7,x2
      ins(1, 1, 0, 1, 0, 7, 1, 1); step();
      ins(1, 7, 2, 1, 1, 8, 1, 0); settle();
      chk("lu stall_id", int'(stall_id), 1);
      chk("lu ex_bubble", int'(ex_bubble), 1);
      step(); settle();
      chk("lu stall released", int'(stall_id), 0);
      chk("lu bubble sel_a", int'(sel_a), 0);
      step();
      nop(); settle();
      chk("lu sel_a", int'(sel_a), 1);
      chk("lu sel_b", int'(sel_b), 0);
      drain();

      // ADD x3 ; ADD x3 ; SUB x9,x3,x0
      ins(1, 1, 2, 1, 1, 3, 1, 0); step();
      ins(1, 1, 2, 1, 1, 3, 1, 0); step();
      ins(1, 3, 0, 1, 1, 9, 1, 0); step();
      nop(); settle();
      chk("prio sel_a", int'(sel_a), 2);
      chk("prio sel_b", int'(sel_b), 0);
      drain();

      // LW x0 ; reader of x0
      ins(1, 1, 0, 1, 0, 0, 1, 1); step();
      ins(1, 0, 0, 1, 1, 4, 1, 0); settle();
      chk("x0 stall_id", int'(stall_id), 0);
      step();
      nop(); settle();
      chk("x0 sel_a", int'(sel_a), 0);
      chk("x0 sel_b", int'(sel_b), 0);
      drain();

      // flush on top of a load-use
      ins(1, 1, 0, 1, 0, 7, 1, 1); step();
      ins(1, 7, 2, 1, 1, 8, 1, 0); flush = 1'b1; settle();
      chk("flush stall_id", int'(stall_id), 0);
      chk("flush ex_bubble", int'(ex_bubble), 1);
      step();
      flush = 1'b0; nop(); settle();
      chk("flush sel_a", int'(sel_a), 0);
      drain();

      // hold for three cycles with SUB in EX
      ins(1, 1, 2, 1, 1, 3, 1, 0); step();
      ins(1, 3, 4, 1, 1, 5, 1, 0); step();
      ins(1, 3, 5, 1, 1, 6, 1, 0); hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("hold sel_a", int'(sel_a), 2);
         chk("hold stall_id", int'(stall_id), 0);
         step();
      end
      hold = 1'b0; settle();
      chk("hold release sel_a", int'(sel_a), 2);
      step();
      nop(); settle();
      chk("resume sel_a", int'(sel_a), 1);
      chk("resume sel_b", int'(sel_b), 2);
      drain();

      // asynchronous reset in the middle of a load-use
      ins(1, 1, 2, 1, 1, 3, 1, 0); step();
      ins(1, 3, 0, 1, 0, 7, 1, 1); step();
      ins(1, 7, 2, 1, 1, 8, 1, 0); settle();
      chk("pre-rst stall_id", int'(stall_id), 1);
      chk("pre-rst sel_a", int'(sel_a), 2);
      rst_n = 1'b0;
      #1;
      chk("async rst sel_a", int'(sel_a), 0);
      chk("async rst sel_b", int'(sel_b), 0);
      chk("async rst stall_id", int'(stall_id), 0);
      chk("async rst ex_bubble", int'(ex_bubble), 0);
      step();
      rst_n = 1'b1; settle();
      chk("post-rst stall_id", int'(stall_id), 0);
      step();
      nop(); settle();
      chk("post-rst sel_a", int'(sel_a), 0);
      chk("post-rst sel_b", int'(sel_b), 0);
      drain();

      // random traffic on a narrow register range to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         ins($urandom_range(0, 9) < 8,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
             int'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
         hold  = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 9) == 0);
         step();
      end
      hold = 1'b0;
      flush = 1'b0;
      nop();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
